// File: rtl/sampling_layer_pool_if.sv
// rtl/sampling_layer_pool_if.sv - pixel stream bundle between a conv layer and the pooling stage
//
// Ports carried:
//   Input_Valid   producer -> pool   pixel bus valid this cycle
//   Input_Finish  producer -> pool   end-of-frame / abort request
//   Input_Pixels  producer -> pool   CHANNELS pixels, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   Output_Pixels pool -> consumer   pooled pixels, same packing
//   Output_Valid  pool -> consumer   one-cycle pulse per completed window
//   Output_Finish pool -> consumer   frame complete, held until reset
interface sampling_layer_pool_if #(
  parameter int CHANNELS   = 6,
  parameter int DATA_WIDTH = 32
);
  logic                           Input_Valid;
  logic                           Input_Finish;
  logic [CHANNELS*DATA_WIDTH-1:0] Input_Pixels;
  logic [CHANNELS*DATA_WIDTH-1:0] Output_Pixels;
  logic                           Output_Valid;
  logic                           Output_Finish;

  modport master (
    output Input_Valid, Input_Finish, Input_Pixels,
    input  Output_Pixels, Output_Valid, Output_Finish
  );

  modport slave (
    input  Input_Valid, Input_Finish, Input_Pixels,
    output Output_Pixels, Output_Valid, Output_Finish
  );
endinterface

// File: rtl/sampling_layer_pool.sv
// rtl/sampling_layer_pool.sv - 2x2 stride-2 max/average pooling over a raster pixel stream
//
// Ports:
//   Clock        rising-edge clock
//   Input_Reset  synchronous active-high reset
//   bus          sampling_layer_pool_if.slave: Input_Valid/Input_Finish/Input_Pixels in,
//                Output_Pixels/Output_Valid/Output_Finish out (all outputs registered)
//
// Horizontal pairs are reduced as they arrive; even rows park their pair result in a
// line buffer of IMG_WIDTH/2 entries, odd rows combine with it to finish the window.
module sampling_layer_pool #(
  parameter int CHANNELS   = 6,
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 24,
  parameter int IMG_HEIGHT = 24,
  parameter int MODE       = 0
) (
  input logic                  Clock,
  input logic                  Input_Reset,
  sampling_layer_pool_if.slave bus
);

  localparam int PW  = DATA_WIDTH + 2;
  localparam int CW  = $clog2(IMG_WIDTH);
  localparam int RW  = $clog2(IMG_HEIGHT);
  localparam int LBW = (CW > 1) ? CW - 1 : 1;
  localparam int LBD = IMG_WIDTH / 2;
  localparam int BW  = CHANNELS * DATA_WIDTH;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [BW-1:0]     partner_q, partner_d;
  logic [BW-1:0]     out_pix_q, out_pix_d;
  logic              out_valid_q, out_valid_d;
  logic              finish_q, finish_d;

  logic [CHANNELS-1:0][PW-1:0] linebuf_q [LBD];
  logic [CHANNELS-1:0][PW-1:0] lb_wdata;
  logic [LBW-1:0]              lb_addr;
  logic                        lb_we;
  logic [BW-1:0]               win_pix;
  logic                        accept;
  logic                        last_pixel;

  assign lb_addr    = LBW'(col_q >> 1);
  assign last_pixel = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Datapath: h is the horizontal reduction of partner and current pixel; on even rows
  // it is what gets stored, on odd rows it merges with the stored partial into the window.
  // Average mode keeps running sums two bits wider so four full-range pixels never overflow.
  always_comb begin
    logic signed [DATA_WIDTH-1:0] pix;
    logic signed [DATA_WIDTH-1:0] prt;
    logic signed [PW-1:0]         pix_x;
    logic signed [PW-1:0]         prt_x;
    logic signed [PW-1:0]         lb_x;
    logic signed [PW-1:0]         h;
    logic signed [PW-1:0]         s;
    lb_wdata = '0;
    win_pix  = '0;
    pix      = '0;
    prt      = '0;
    pix_x    = '0;
    prt_x    = '0;
    lb_x     = '0;
    h        = '0;
    s        = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      pix   = bus.Input_Pixels[k*DATA_WIDTH +: DATA_WIDTH];
      prt   = partner_q[k*DATA_WIDTH +: DATA_WIDTH];
      pix_x = {{2{pix[DATA_WIDTH-1]}}, pix};
      prt_x = {{2{prt[DATA_WIDTH-1]}}, prt};
      lb_x  = linebuf_q[lb_addr][k];
      if (MODE == 0) begin
        h = (pix_x > prt_x) ? pix_x : prt_x;
        s = (lb_x > h) ? lb_x : h;
      end else begin
        h = pix_x + prt_x;
        s = (lb_x + h) >>> 2;  // floor toward -inf
      end
      lb_wdata[k] = h;
      win_pix[k*DATA_WIDTH +: DATA_WIDTH] = s[DATA_WIDTH-1:0];
    end
  end

  // Control: counters advance only on accepted pixels; Finish (or the last pixel) moves
  // to DONE after the same-cycle pixel, if any, has been processed.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    partner_d   = partner_q;
    out_pix_d   = out_pix_q;
    out_valid_d = 1'b0;
    finish_d    = finish_q;
    lb_we       = 1'b0;
    accept      = 1'b0;
    if (state_q != ST_DONE) begin
      accept = bus.Input_Valid;
      if (accept) begin
        if (!col_q[0]) begin
          partner_d = bus.Input_Pixels;
        end else if (!row_q[0]) begin
          lb_we = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          out_pix_d   = win_pix;
        end
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      if (bus.Input_Finish || (accept && last_pixel)) begin
        state_d  = ST_DONE;
        finish_d = 1'b1;
      end else if (accept) begin
        state_d = ST_ACTIVE;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Input_Reset) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      partner_q   <= '0;
      out_pix_q   <= '0;
      out_valid_q <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      partner_q   <= partner_d;
      out_pix_q   <= out_pix_d;
      out_valid_q <= out_valid_d;
      finish_q    <= finish_d;
    end
  end

  // Line buffer contents are always rewritten by an even row before an odd row reads
  // them, so no reset is needed and the array can map onto RAM.
  always_ff @(posedge Clock) begin
    if (lb_we && !Input_Reset) begin
      linebuf_q[lb_addr] <= lb_wdata;
    end
  end

  assign bus.Output_Pixels = out_pix_q;
  assign bus.Output_Valid  = out_valid_q;
  assign bus.Output_Finish = finish_q;

endmodule

// File: tb/tb_sampling_layer_pool.sv
// tb/tb_sampling_layer_pool.sv - directed and model-checked bench for sampling_layer_pool
module tb_sampling_layer_pool;
  localparam int DW  = 32;
  localparam int BCH = 6;
  localparam int BW  = 24;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sampling_layer_pool_if #(.CHANNELS(1),   .DATA_WIDTH(DW)) bus_max ();
  sampling_layer_pool_if #(.CHANNELS(1),   .DATA_WIDTH(DW)) bus_avg ();
  sampling_layer_pool_if #(.CHANNELS(BCH), .DATA_WIDTH(DW)) bus_big ();

  sampling_layer_pool #(.CHANNELS(1), .DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4), .MODE(0))
    dut_max (.Clock(clk), .Input_Reset(rst), .bus(bus_max.slave));
  sampling_layer_pool #(.CHANNELS(1), .DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4), .MODE(1))
    dut_avg (.Clock(clk), .Input_Reset(rst), .bus(bus_avg.slave));
  sampling_layer_pool #(.CHANNELS(BCH), .DATA_WIDTH(DW), .IMG_WIDTH(BW), .IMG_HEIGHT(BW), .MODE(0))
    dut_big (.Clock(clk), .Input_Reset(rst), .bus(bus_big.slave));

  int checks = 0;
  int errors = 0;

  localparam logic signed [DW-1:0] SMAX = 32'sh7fffffff;
  localparam logic signed [DW-1:0] SMIN = 32'sh80000000;

  int exp_max_frame [4] = '{5, 7, 13, 15};
  int exp_avg_frame [4] = '{2, 4, 10, 12};

  logic signed [DW-1:0] img [BW][BW][BCH];

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus_max.Input_Valid = 1'b0; bus_max.Input_Finish = 1'b0; bus_max.Input_Pixels = '0;
    bus_avg.Input_Valid = 1'b0; bus_avg.Input_Finish = 1'b0; bus_avg.Input_Pixels = '0;
    bus_big.Input_Valid = 1'b0; bus_big.Input_Finish = 1'b0; bus_big.Input_Pixels = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drive both 4x4 instances for one clock and sample just after the edge.
  task automatic small_step(input logic v, input logic f, input logic signed [DW-1:0] p);
    bus_max.Input_Valid = v; bus_max.Input_Finish = f; bus_max.Input_Pixels = p;
    bus_avg.Input_Valid = v; bus_avg.Input_Finish = f; bus_avg.Input_Pixels = p;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rst_pix_max"}, bus_max.Output_Pixels, 0);
    check({tag, "_rst_valid_max"}, bus_max.Output_Valid, 0);
    check({tag, "_rst_fin_max"}, bus_max.Output_Finish, 0);
    check({tag, "_rst_pix_avg"}, bus_avg.Output_Pixels, 0);
    check({tag, "_rst_valid_avg"}, bus_avg.Output_Valid, 0);
    check({tag, "_rst_fin_avg"}, bus_avg.Output_Finish, 0);
  endtask

  // Pixels 0..15 in raster order, optionally with 1-3 idle cycles between pixels.
  task automatic full_frame(input string tag, input bit gaps);
    int ridx;
    logic ev;
    ridx = 0;
    for (int p = 0; p < 16; p++) begin
      if (gaps && p > 0) begin
        repeat ($urandom_range(1, 3)) begin
          small_step(1'b0, 1'b0, 32'sd999);
          check({tag, "_gap_valid"}, bus_max.Output_Valid, 0);
          if (ridx > 0) check({tag, "_gap_hold"}, $signed(bus_max.Output_Pixels), exp_max_frame[ridx-1]);
        end
      end
      small_step(1'b1, p == 15, p);
      ev = ((p / 4) % 2 == 1) && ((p % 4) % 2 == 1);
      check({tag, "_valid_max"}, bus_max.Output_Valid, ev);
      check({tag, "_valid_avg"}, bus_avg.Output_Valid, ev);
      if (ev) begin
        check({tag, "_pix_max"}, $signed(bus_max.Output_Pixels), exp_max_frame[ridx]);
        check({tag, "_pix_avg"}, $signed(bus_avg.Output_Pixels), exp_avg_frame[ridx]);
        ridx++;
      end
      check({tag, "_fin_max"}, bus_max.Output_Finish, p == 15);
      check({tag, "_fin_avg"}, bus_avg.Output_Finish, p == 15);
    end
    small_step(1'b1, 1'b0, 32'sd77);
    check({tag, "_done_valid"}, bus_max.Output_Valid, 0);
    check({tag, "_done_fin"}, bus_max.Output_Finish, 1);
    check({tag, "_done_hold"}, $signed(bus_max.Output_Pixels), 15);
  endtask

  // First window gets a,b (row 0) and c,d (row 1); other pixels are zero.
  task automatic window_test(input string tag,
                             input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                             input logic signed [DW-1:0] c, input logic signed [DW-1:0] d,
                             input logic signed [DW-1:0] emax, input logic signed [DW-1:0] eavg);
    logic signed [DW-1:0] val;
    do_reset();
    for (int p = 0; p < 6; p++) begin
      val = (p == 0) ? a : (p == 1) ? b : (p == 4) ? c : (p == 5) ? d : 32'sd0;
      small_step(1'b1, 1'b0, val);
    end
    check({tag, "_valid"}, bus_max.Output_Valid, 1);
    check({tag, "_max"}, $signed(bus_max.Output_Pixels), emax);
    check({tag, "_avg"}, $signed(bus_avg.Output_Pixels), eavg);
    small_step(1'b0, 1'b1, 32'sd0);
    check({tag, "_fin"}, bus_avg.Output_Finish, 1);
  endtask

  task automatic big_frame();
    logic [BCH*DW-1:0] packed_pix;
    logic signed [DW-1:0] e;
    logic ev;
    int oidx, wr, wc;
    for (int r = 0; r < BW; r++)
      for (int c = 0; c < BW; c++)
        for (int k = 0; k < BCH; k++)
          img[r][c][k] = $signed($urandom());
    do_reset();
    oidx = 0;
    for (int r = 0; r < BW; r++) begin
      for (int c = 0; c < BW; c++) begin
        for (int k = 0; k < BCH; k++) packed_pix[k*DW +: DW] = img[r][c][k];
        bus_big.Input_Valid  = 1'b1;
        bus_big.Input_Pixels = packed_pix;
        @(posedge clk); #1;
        ev = (r % 2 == 1) && (c % 2 == 1);
        if (bus_big.Output_Valid !== ev) check("t3_valid", bus_big.Output_Valid, ev);
        if (ev && bus_big.Output_Valid === 1'b1) begin
          wr = oidx / (BW / 2);
          wc = oidx % (BW / 2);
          for (int k = 0; k < BCH; k++) begin
            e = smax(smax(img[2*wr][2*wc][k], img[2*wr][2*wc+1][k]),
                     smax(img[2*wr+1][2*wc][k], img[2*wr+1][2*wc+1][k]));
            check("t3_pix", $signed(bus_big.Output_Pixels[k*DW +: DW]), e);
          end
          oidx++;
        end
      end
    end
    bus_big.Input_Valid = 1'b0;
    check("t3_count", oidx, (BW / 2) * (BW / 2));
    check("t3_fin", bus_big.Output_Finish, 1);
  endtask

  initial begin
    do_reset();
    check_reset_state("t0");

    // T1/T2: continuous frame, Finish with the last pixel
    full_frame("t1", 1'b0);

    // Window edge cases: negatives, extremes, mixed signs
    window_test("t2_neg", -32'sd1, -32'sd2, -32'sd3, -32'sd4, -32'sd1, -32'sd3);
    window_test("t2_top", SMAX, SMAX, SMAX, SMAX - 1, SMAX, SMAX - 1);
    window_test("t2_bot", SMIN, SMIN, SMIN, SMIN, SMIN, SMIN);
    window_test("t2_mix", SMIN, SMAX, -32'sd5, 32'sd3, SMAX, -32'sd1);
    window_test("t2_mix2", 32'sd7, -32'sd8, 32'sd2, -32'sd9, 32'sd7, -32'sd2);

    // T3: 6-channel 24x24 random frame against the model
    big_frame();

    // T4: gaps between pixels
    do_reset();
    full_frame("t4", 1'b1);

    // T5: truncation with pixel 9
    do_reset();
    for (int p = 0; p < 10; p++) begin
      small_step(1'b1, p == 9, p);
      if (p == 5) check("t5_pix0", $signed(bus_max.Output_Pixels), 5);
      if (p == 7) check("t5_pix1", $signed(bus_max.Output_Pixels), 7);
      check("t5_valid", bus_max.Output_Valid, (p == 5) || (p == 7));
      check("t5_fin", bus_max.Output_Finish, p == 9);
    end
    for (int p = 10; p < 16; p++) begin
      small_step(1'b1, 1'b0, p);
      check("t5_ignored_valid", bus_max.Output_Valid, 0);
      check("t5_fin_held", bus_max.Output_Finish, 1);
    end

    // IDLE with Finish and no pixel goes straight to DONE
    do_reset();
    small_step(1'b0, 1'b1, 32'sd0);
    check("idle_fin", bus_max.Output_Finish, 1);
    check("idle_fin_valid", bus_max.Output_Valid, 0);
    for (int p = 0; p < 6; p++) small_step(1'b1, 1'b0, p);
    check("idle_done_ignored", bus_max.Output_Valid, 0);

    // T6: reset mid-frame, then a clean frame
    do_reset();
    for (int p = 0; p < 7; p++) begin
      small_step(1'b1, 1'b0, 100 + p);
      if (p == 5) check("t6_pre_pix", $signed(bus_max.Output_Pixels), 105);
    end
    do_reset();
    check_reset_state("t6");
    full_frame("t6", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
